// File: rtl/pc_callstack.sv
// ---------------------------------------------------------------------------
// pc_callstack
//   Parametrised program counter with a hardware return-address stack.
//   The PC can be loaded from the shared bus, incremented, optionally moved
//   by a signed bus offset (PC_REL_EN), and driven back onto the bus.
//   call pushes PC+1 and jumps to the bus value; ret pops the most recent
//   return address. The stack is a circular buffer: a call on a full stack
//   overwrites the oldest entry. Sticky ovf/unf flags record call-when-full
//   and ret-when-empty. Only reset clears the flags.
//
//   Optional feature macro: PC_REL_EN
//     defined   : rel performs value <= value + bus (two's complement offset)
//     undefined : rel is ignored; no adder beyond the +1 incrementer exists
//
// Ports
//   clk    in     posedge clock for all state
//   reset  in     asynchronous, active-high reset
//   bus    inout  shared bus; driven with value when en=1, otherwise Z
//   en     in     drive value onto bus (combinational)
//   load   in     value <= bus
//   inc    in     value <= value + 1
//   call   in     push value+1, value <= bus
//   ret    in     value <= pop
//   rel    in     value <= value + bus (only with PC_REL_EN)
//   value  out    current PC
//   depth  out    number of valid stack entries, 0..DEPTH
//   ovf    out    sticky: call issued while stack full
//   unf    out    sticky: ret issued while stack empty
//
// Handshake: there is none. Strobes are level signals sampled only at the
//   rising clock edge; exactly one action is taken per edge with priority
//   ret > call > load > rel > inc > hold. Results appear after that edge.
// ---------------------------------------------------------------------------
module pc_callstack #(
    parameter int                WIDTH       = 16,
    parameter int                DEPTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    inout  wire  [WIDTH-1:0]           bus,
    input  logic                       en,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       rel,
    output logic [WIDTH-1:0]           value,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       ovf,
    output logic                       unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    // Return-address storage; contents are don't-care after reset.
    logic [WIDTH-1:0] stack_mem [DEPTH];

    logic [WIDTH-1:0] value_q, value_d;
    logic [AW-1:0]    head_q,  head_d;   // next slot to write
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q,   ovf_d;
    logic             unf_q,   unf_d;

    logic             push_en;
    logic [WIDTH-1:0] pc_plus1;
    logic [AW-1:0]    head_m1;

    assign pc_plus1 = value_q + WIDTH'(1);
    assign head_m1  = head_q - AW'(1);

    assign bus = en ? value_q : 'z;

`ifndef PC_REL_EN
    logic unused_rel;
    assign unused_rel = rel;
`endif

    always_comb begin
        value_d = value_q;
        head_d  = head_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;

        if (ret) begin
            if (depth_q != '0) begin
                value_d = stack_mem[head_m1];
                head_d  = head_m1;
                depth_d = depth_q - DW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end else if (call) begin
            // When full, head already points at the oldest entry, so the
            // push naturally overwrites it and depth saturates.
            push_en = 1'b1;
            head_d  = head_q + AW'(1);
            value_d = bus;
            if (depth_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                depth_d = depth_q + DW'(1);
            end
        end else if (load) begin
            value_d = bus;
`ifdef PC_REL_EN
        end else if (rel) begin
            // Modulo add: a negative offset in two's complement wraps down.
            value_d = value_q + bus;
`endif
        end else if (inc) begin
            value_d = pc_plus1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= RESET_VALUE;
            head_q  <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            head_q  <= head_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage has no reset; a push during reset is harmless because depth
    // is held at zero.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[head_q] <= pc_plus1;
        end
    end

    assign value = value_q;
    assign depth = depth_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_pc_callstack.sv
module tb_pc_callstack;

    localparam int DEPTH = 8;
`ifdef PC_REL_EN
    localparam bit REL_ON = 1'b1;
`else
    localparam bit REL_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        en = 1'b0;
    logic        load = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0, rel = 1'b0;
    logic        drv_en = 1'b0;
    logic [15:0] drv_val = '0;
    wire  [15:0] bus;
    logic [15:0] value;
    logic [3:0]  depth;
    logic        ovf, unf;

    assign bus = drv_en ? drv_val : 'z;

    pc_callstack #(.WIDTH(16), .DEPTH(DEPTH), .RESET_VALUE(16'd0)) dut (
        .clk(clk), .reset(reset), .bus(bus), .en(en),
        .load(load), .inc(inc), .call(call), .ret(ret), .rel(rel),
        .value(value), .depth(depth), .ovf(ovf), .unf(unf)
    );

    // ---------------- reference model ----------------
    int unsigned m_pc;
    int unsigned m_stk[$];
    bit          m_ovf, m_unf;

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_apply(bit l, bit i, bit c, bit r, bit rl, int unsigned b);
        if (r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_unf = 1'b1;
        end else if (c) begin
            if (m_stk.size() == DEPTH) begin
                void'(m_stk.pop_front());
                m_ovf = 1'b1;
            end
            m_stk.push_back((m_pc + 1) % 65536);
            m_pc = b;
        end else if (l) begin
            m_pc = b;
        end else if (rl && REL_ON) begin
            m_pc = (m_pc + b) % 65536;
        end else if (i) begin
            m_pc = (m_pc + 1) % 65536;
        end
    endtask

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(string tag);
        check({tag, ".value"}, {16'h0, value}, m_pc);
        check({tag, ".depth"}, {28'h0, depth}, m_stk.size());
        check({tag, ".ovf"},   {31'h0, ovf},   {31'h0, m_ovf});
        check({tag, ".unf"},   {31'h0, unf},   {31'h0, m_unf});
    endtask

    // ---------------- driver ----------------
    // Called just after a posedge; drives strobes, takes one edge, samples at +1.
    task automatic step(bit l, bit i, bit c, bit r, bit rl, logic [15:0] b);
        en = 1'b0; drv_en = 1'b1; drv_val = b;
        load = l; inc = i; call = c; ret = r; rel = rl;
        model_apply(l, i, c, r, rl, b);
        @(posedge clk); #1;
        load = 0; inc = 0; call = 0; ret = 0; rel = 0;
    endtask

    task automatic read_bus(string tag);
        drv_en = 1'b0; en = 1'b1;
        #1;
        check(tag, {16'h0, bus}, m_pc);
        en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_model("post_reset");

        // 1: async reset mid-cycle with random strobes and some history
        step(1, 0, 0, 0, 0, 16'd1234);
        step(0, 0, 1, 0, 0, 16'd77);
        step(0, 0, 0, 1, 0, 16'd0);
        step(0, 0, 0, 1, 0, 16'd0);           // underflow sets unf
        load = 1'($urandom_range(0, 1)); inc = 1'($urandom_range(0, 1));
        call = 1'($urandom_range(0, 1)); ret = 1'($urandom_range(0, 1));
        drv_en = 1'b1; drv_val = 16'($urandom);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("async_rst.value", {16'h0, value}, 32'd0);
        check("async_rst.depth", {28'h0, depth}, 32'd0);
        check("async_rst.flags", {30'h0, ovf, unf}, 32'd0);
        load = 0; inc = 0; call = 0; ret = 0;
        @(posedge clk); #3 reset = 1'b0;
        @(posedge clk); #1;
        check_model("rst_release");

        // 2: load / inc / wrap
        step(1, 0, 0, 0, 0, 16'd1500);
        step(0, 1, 0, 0, 0, 16'd0);
        check("inc_1501", {16'h0, value}, 32'd1501);
        inc = 1'b1; #2;
        check("inc_no_edge", {16'h0, value}, 32'd1501);
        inc = 1'b0;
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0, 16'hFFFF);
        step(0, 1, 0, 0, 0, 16'd0);
        check("inc_wrap", {16'h0, value}, 32'd0);

        // 3: call / ret nesting
        step(1, 0, 0, 0, 0, 16'd100);
        step(0, 0, 1, 0, 0, 16'd500);
        check_model("call500");
        check("call500_val", {16'h0, value}, 32'd500);
        step(0, 0, 1, 0, 0, 16'd900);
        check("call900_depth", {28'h0, depth}, 32'd2);
        step(0, 0, 0, 1, 0, 16'd0);
        check("ret_501", {16'h0, value}, 32'd501);
        step(0, 0, 0, 1, 0, 16'd0);
        check("ret_101", {16'h0, value}, 32'd101);
        check("ret_depth0", {28'h0, depth}, 32'd0);

        // 4: overflow and underflow around a full stack
        step(1, 0, 0, 0, 0, 16'd0);
        for (int k = 1; k <= 9; k++) step(0, 0, 1, 0, 0, 16'(k * 10));
        check("ovf_set", {31'h0, ovf}, 32'd1);
        check("ovf_depth", {28'h0, depth}, 32'd8);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 1, 0, 16'd0);
            check("pop_seq", {16'h0, value}, 32'(81 - 10 * k));
        end
        check("unf_before", {31'h0, unf}, 32'd0);
        step(0, 0, 0, 1, 0, 16'd0);
        check("unf_hold", {16'h0, value}, 32'd11);
        check("unf_set", {31'h0, unf}, 32'd1);
        check_model("after_unf");

        // 5: priority
        step(0, 0, 1, 0, 0, 16'd300);
        step(0, 0, 1, 1, 0, 16'd700);
        check("ret_beats_call.depth", {28'h0, depth}, 32'd0);
        check("ret_beats_call.value", {16'h0, value}, 32'd12);
        step(1, 1, 0, 0, 0, 16'd4000);
        check("load_beats_inc", {16'h0, value}, 32'd4000);
        step(1, 0, 0, 0, 1, 16'd5);
        check("load_beats_rel", {16'h0, value}, 32'd5);

        // 6: relative branch and bus direction
        step(1, 0, 0, 0, 0, 16'd6502);
        step(0, 0, 0, 0, 1, 16'hFFF6);
        check("rel_only", {16'h0, value}, REL_ON ? 32'd6492 : 32'd6502);
        step(0, 1, 0, 0, 1, 16'd3);
        check_model("rel_inc");
        read_bus("bus_en1");
        drv_en = 1'b1; drv_val = 16'd2056; #1;
        check("bus_en0", {16'h0, bus}, 32'd2056);
        @(posedge clk); #1;

        // randomized run against the model
        for (int n = 0; n < 400; n++) begin
            logic [15:0] b;
            b = (($urandom_range(0, 3) == 0)) ? 16'($urandom) : 16'($urandom_range(0, 40));
            step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0), b);
            check_model("rand");
            if ($urandom_range(0, 7) == 0) read_bus("rand_bus");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
